pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Consumer side of the hazard-request interface in the mips32 pipeline.
//  Takes load-use, jump-in-ID and branch/jump-resolved-in-MEM requests.
//  Drives PC write enable, IF/ID enable and per-stage flushes.
//  Sequences multi-cycle jump bubbles with an FSM, and keeps saturating
//  stall/flush counters plus a jump-timeout watchdog.
// PARAMETERS
//  CNT_W        16  width of the stall_cnt and flush_cnt performance counters
//  JUMP_TIMEOUT 8   max cycles in JWAIT before timeout_err; must be >=2
// PORTS
//  clock       in  1      single clock; all state changes on its rising edge
//  reset       in  1      asynchronous, active-high; clears all state
//  load_use    in  1      ID instr reads a reg loaded by the EX-stage lw
//  jump_id     in  1      jump decoded in ID this cycle
//  jump_done   in  1      jump reached MEM; target is valid on the PC mux
//  branch_mem  in  1      branch taken, resolved in MEM
//  pc_en       out 1      PC register write enable
//  ifid_en     out 1      IF/ID register write enable (0 = hold)
//  ifid_flush  out 1      load NOP into IF/ID
//  idex_flush  out 1      load NOP into ID/EX
//  exmem_flush out 1      load NOP into EX/MEM
//  jwait       out 1      high while FSM is in JWAIT
//  timeout_err out 1      sticky; JWAIT exceeded JUMP_TIMEOUT cycles
//  stall_cnt   out CNT_W  cycles with pc_en=0, saturating
//  flush_cnt   out CNT_W  branch flush events, saturating
// BEHAVIOUR
//  - Flush/enable outputs are combinational from state and inputs, same cycle.
//  - Counters, FSM and timeout_err are registered.
//  - Reset values: state=RUN, wdog=0, stall_cnt=0, flush_cnt=0, timeout_err=0.
//  - With RUN and no requests active: pc_en=1, ifid_en=1, all flushes=0.
//  - Priority each cycle: branch_mem > load_use > jump_id (in RUN);
//    in JWAIT: branch_mem > jump_done > hold.
//  - RUN + branch_mem: ifid/idex/exmem_flush=1 and pc_en=1 (PC loads target).
//    flush_cnt+1. Stay in RUN. Same-cycle load_use/jump_id are discarded.
//  - RUN + load_use: pc_en=0, ifid_en=0, idex_flush=1 for exactly that cycle.
//    stall_cnt+1. A pending jump_id is ignored; it re-asserts next cycle.
//  - RUN + jump_id: pc_en=0 (hold), ifid_flush=1. Next state JWAIT, wdog=0.
//  - JWAIT: pc_en=0, ifid_flush=1 (bubble per cycle), ifid_en=1, jwait=1.
//    stall_cnt+1 per cycle; wdog+1 per cycle.
//  - JWAIT + jump_done: pc_en=1, ifid_flush=1, next state RUN.
//    This is the last stall-free bubble, so stall_cnt is not incremented.
//  - JWAIT + branch_mem: same outputs as the RUN branch case, next state RUN.
//    The older branch overrides the jump.
//  - JWAIT when wdog reaches JUMP_TIMEOUT-1 without jump_done:
//    timeout_err<=1 and force RUN with pc_en=1 (recovery).
//  - jump_done in RUN is ignored. load_use in JWAIT is ignored, since
//    IF/ID already holds bubbles.
//  - Counters saturate at 2^CNT_W-1 and never wrap.
//  - Reset mid-JWAIT: return to RUN on assertion. Outputs take their RUN
//    idle values while reset is high.
// STRUCTURE
//  - Shared package mips_pkg: state encoding localparams ST_RUN=1'b0 and
//    ST_JWAIT=1'b1, and the NOP instruction constant used by flush consumers.
//  - One sub-module sat_counter #(W): enable, saturating increment,
//    async reset. Instantiated twice, for stall_cnt and flush_cnt.
//  - Top level holds the FSM, the wdog counter, the output decode and
//    timeout_err.
// TESTING
//  1. Reset pulse mid-run -> pc_en=1, ifid_en=1, flushes=0, counters=0,
//     timeout_err=0.
//  2. load_use=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle
//     only; stall_cnt=1.
//  3. jump_id, then jump_done 3 cycles later -> jwait=1 for 3 cycles,
//     ifid_flush=1 for 4 cycles, pc_en=1 on the jump_done cycle;
//     stall_cnt=3 (1 in RUN + 2 in JWAIT).
//  4. jump_id, then branch_mem in JWAIT -> all 3 flushes=1 and pc_en=1;
//     state RUN next cycle; flush_cnt=1.
//  5. branch_mem, load_use and jump_id in the same cycle -> branch outputs
//     only; no stall_cnt increment; state stays RUN.
//  6. jump_id with jump_done never asserted, JUMP_TIMEOUT=8 -> timeout_err
//     rises after 8 JWAIT cycles and stays set; state returns to RUN.
//  7. CNT_W=4 with 20 load_use cycles -> stall_cnt holds at 15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared mips32 pipeline definitions: hazard-FSM state encoding and the NOP
// word that flush consumers load into pipeline registers.
package mips_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_JWAIT = 1'b1
  } stall_state_e;

  // sll $0,$0,0 -- the canonical mips32 NOP
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard-request consumer for the mips32 pipeline: PC/IF-ID enables, stage
// flushes, jump-bubble FSM with watchdog, and saturating stall/flush counters.
module pipeline_stall_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int JUMP_TIMEOUT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_use,
  input  logic             jump_id,
  input  logic             jump_done,
  input  logic             branch_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             jwait,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WD_W = (JUMP_TIMEOUT > 2) ? $clog2(JUMP_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(JUMP_TIMEOUT - 1);

  stall_state_e    state_q, state_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            terr_q, terr_d;

  logic pc_en_c, ifid_en_c, ifid_fl_c, idex_fl_c, exmem_fl_c;
  logic stall_inc, flush_inc;

  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    terr_d     = terr_q;
    pc_en_c    = 1'b1;
    ifid_en_c  = 1'b1;
    ifid_fl_c  = 1'b0;
    idex_fl_c  = 1'b0;
    exmem_fl_c = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (branch_mem) begin
          ifid_fl_c  = 1'b1;
          idex_fl_c  = 1'b1;
          exmem_fl_c = 1'b1;
          flush_inc  = 1'b1;
        end else if (load_use) begin
          pc_en_c   = 1'b0;
          ifid_en_c = 1'b0;
          idex_fl_c = 1'b1;
          stall_inc = 1'b1;
        end else if (jump_id) begin
          pc_en_c   = 1'b0;
          ifid_fl_c = 1'b1;
          stall_inc = 1'b1;
          state_d   = ST_JWAIT;
          wdog_d    = '0;
        end
      end
      ST_JWAIT: begin
        ifid_fl_c = 1'b1;
        if (branch_mem) begin
          // the older branch in MEM supersedes the pending jump
          idex_fl_c  = 1'b1;
          exmem_fl_c = 1'b1;
          flush_inc  = 1'b1;
          state_d    = ST_RUN;
        end else if (jump_done) begin
          state_d = ST_RUN;
        end else if (wdog_q == WD_LAST) begin
          // watchdog recovery: release the PC and flag the lost jump
          terr_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          pc_en_c   = 1'b0;
          stall_inc = 1'b1;
          wdog_d    = wdog_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      wdog_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      terr_q  <= terr_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (stall_inc),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (flush_inc),
    .cnt_o (flush_cnt)
  );

  // while reset is held the pipeline sees plain RUN/idle controls
  assign pc_en       = reset | pc_en_c;
  assign ifid_en     = reset | ifid_en_c;
  assign ifid_flush  = ~reset & ifid_fl_c;
  assign idex_flush  = ~reset & idex_fl_c;
  assign exmem_flush = ~reset & exmem_fl_c;
  assign jwait       = ~reset & (state_q == ST_JWAIT);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_stall_ctrl;

  localparam int CW = 4;
  localparam int JT = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic load_use = 0, jump_id = 0, jump_done = 0, branch_mem = 0;
  logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, jwait, timeout_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  // model state
  bit m_jump;
  int m_age;
  bit m_err;
  int m_stall, m_flush;

  logic [6:0] obs;
  assign obs = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, jwait, timeout_err};

  always #5 clock = ~clock;

  pipeline_stall_ctrl #(.CNT_W(CW), .JUMP_TIMEOUT(JT)) dut (
    .clock(clock), .reset(reset), .load_use(load_use), .jump_id(jump_id),
    .jump_done(jump_done), .branch_mem(branch_mem), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .jwait(jwait), .timeout_err(timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // expected {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, jwait, timeout_err}
  function automatic logic [6:0] exp_out();
    bit pc = 1, ie = 1, ff = 0, df = 0, ef = 0;
    if (reset) return 7'b1100000;
    if (!m_jump) begin
      if (branch_mem) begin ff = 1; df = 1; ef = 1; end
      else if (load_use) begin pc = 0; ie = 0; df = 1; end
      else if (jump_id) begin pc = 0; ff = 1; end
    end else begin
      ff = 1;
      if (branch_mem) begin df = 1; ef = 1; end
      else if (!jump_done && m_age != JT - 1) pc = 0;
    end
    return {pc, ie, ff, df, ef, m_jump, m_err};
  endfunction

  task automatic m_clear();
    m_jump = 0; m_age = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  // advance the model one clock using the currently applied inputs
  task automatic m_step();
    int ds = 0, df = 0;
    if (!m_jump) begin
      if (branch_mem) df = 1;
      else if (load_use) ds = 1;
      else if (jump_id) begin ds = 1; m_jump = 1; m_age = 0; end
    end else if (branch_mem) begin
      df = 1; m_jump = 0;
    end else if (jump_done) begin
      m_jump = 0;
    end else if (m_age == JT - 1) begin
      m_err = 1; m_jump = 0;
    end else begin
      ds = 1; m_age++;
    end
    m_stall = (m_stall + ds > CMAX) ? CMAX : m_stall + ds;
    m_flush = (m_flush + df > CMAX) ? CMAX : m_flush + df;
  endtask

  task automatic drive(input logic br, input logic lu, input logic jid, input logic jd);
    @(negedge clock);
    branch_mem = br; load_use = lu; jump_id = jid; jump_done = jd;
    #1;
  endtask

  task automatic tick();
    m_step();
    @(posedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    branch_mem = 0; load_use = 0; jump_id = 0; jump_done = 0;
    reset = 1;
    m_clear();
    #2 reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 0);
    checks++;
    if (obs !== 7'b1100000 || stall_cnt !== 0 || flush_cnt !== 0) begin
      failures++;
      $display("FAIL reset_idle obs=%b stall=%0d flush=%0d want obs=1100000 cnt=0", obs, stall_cnt, flush_cnt);
    end
    drive(0, 0, 1, 0); tick();
    drive(1, 1, 1, 0);
    #1 reset = 1;
    #1;
    checks++;
    if (obs !== 7'b1100000 || stall_cnt !== 0 || flush_cnt !== 0) begin
      failures++;
      $display("FAIL reset_mid_jwait obs=%b stall=%0d flush=%0d want obs=1100000 cnt=0", obs, stall_cnt, flush_cnt);
    end
    m_clear();
    branch_mem = 0; load_use = 0; jump_id = 0;
    #1 reset = 0;
    @(posedge clock);
    drive(0, 0, 0, 0);
    checks++;
    if (obs !== 7'b1100000) begin
      failures++;
      $display("FAIL reset_after_run obs=%b want 1100000", obs);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 1, 0, 0);
    checks++;
    if (obs !== 7'b0001000) begin
      failures++;
      $display("FAIL load_use_stall obs=%b want 0001000", obs);
    end
    tick();
    drive(0, 0, 0, 0);
    checks++;
    if (obs !== 7'b1100000 || stall_cnt !== 4'd1) begin
      failures++;
      $display("FAIL load_use_release obs=%b stall=%0d want obs=1100000 stall=1", obs, stall_cnt);
    end
    tick();
  endtask

  task automatic test_jump_done();
    int n_jw = 0, n_ff = 0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, c == 0, c == 3);
      n_jw += int'(jwait);
      n_ff += int'(ifid_flush);
      checks++;
      if (obs !== exp_out()) begin
        failures++;
        $display("FAIL jump_seq cyc=%0d obs=%b want %b", c, obs, exp_out());
      end
      tick();
    end
    drive(0, 0, 0, 0);
    checks++;
    if (n_jw != 3 || n_ff != 4 || stall_cnt !== 4'd3 || jwait !== 1'b0) begin
      failures++;
      $display("FAIL jump_totals jwait=%0d ifid_flush=%0d stall=%0d jw=%b want 3 4 3 0", n_jw, n_ff, stall_cnt, jwait);
    end
    tick();
  endtask

  task automatic test_jump_branch();
    do_reset();
    drive(0, 0, 1, 0); tick();
    drive(1, 0, 0, 0);
    checks++;
    if (obs !== 7'b1111110) begin
      failures++;
      $display("FAIL jwait_branch obs=%b want 1111110", obs);
    end
    tick();
    drive(0, 0, 0, 0);
    checks++;
    if (obs !== 7'b1100000 || flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin
      failures++;
      $display("FAIL jwait_branch_after obs=%b flush=%0d stall=%0d want 1100000 1 1", obs, flush_cnt, stall_cnt);
    end
    tick();
  endtask

  task automatic test_priority();
    do_reset();
    drive(1, 1, 1, 0);
    checks++;
    if (obs !== 7'b1111100) begin
      failures++;
      $display("FAIL prio_all obs=%b want 1111100", obs);
    end
    tick();
    drive(0, 0, 0, 0);
    checks++;
    if (obs !== 7'b1100000 || stall_cnt !== 0 || flush_cnt !== 4'd1) begin
      failures++;
      $display("FAIL prio_after obs=%b stall=%0d flush=%0d want 1100000 0 1", obs, stall_cnt, flush_cnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    drive(0, 0, 1, 0); tick();
    for (int i = 0; i < JT; i++) begin
      drive(0, 0, 0, 0);
      checks++;
      if (obs !== exp_out() || jwait !== 1'b1 || timeout_err !== 1'b0 || pc_en !== (i == JT - 1)) begin
        failures++;
        $display("FAIL timeout_wait i=%0d obs=%b want %b", i, obs, exp_out());
      end
      tick();
    end
    drive(0, 0, 0, 0);
    checks++;
    if (timeout_err !== 1'b1 || jwait !== 1'b0 || pc_en !== 1'b1 || stall_cnt !== 4'd8) begin
      failures++;
      $display("FAIL timeout_rise terr=%b jw=%b pc=%b stall=%0d want 1 0 1 8", timeout_err, jwait, pc_en, stall_cnt);
    end
    tick();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky terr=%b want 1", timeout_err);
    end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) begin drive(0, 1, 0, 0); tick(); end
    drive(0, 0, 0, 0);
    checks++;
    if (stall_cnt !== 4'd15) begin
      failures++;
      $display("FAIL stall_saturate stall=%0d want 15", stall_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) do_reset();
      drive($urandom_range(7) == 0, $urandom_range(3) == 0,
            $urandom_range(3) == 0, $urandom_range(5) == 0);
      checks++;
      if (obs !== exp_out() || stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush)) begin
        failures++;
        $display("FAIL random i=%0d obs=%b stall=%0d flush=%0d want %b %0d %0d",
                 i, obs, stall_cnt, flush_cnt, exp_out(), m_stall, m_flush);
      end
      tick();
    end
  endtask

  initial begin
    m_clear();
    repeat (2) @(posedge clock);
    test_reset();
    test_load_use();
    test_jump_done();
    test_jump_branch();
    test_priority();
    test_timeout();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
